// File: rtl/clock_divider_bank.sv
// Bank of independent programmable clock dividers sharing one synchronous restart.
// Each channel toggles clk_out every (prescale+1) cycles and strobes tick/rise_tick on each toggle.
module clock_divider_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  input  logic [NUM_CH*CNT_W-1:0] clk_prescale,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic                    sync_restart,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       rise_tick
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] prescale;
    logic [CNT_W-1:0] limit;
    logic             at_limit;
    logic             clk_q;
    logic             tick_q;
    logic             rise_q;

    assign prescale = clk_prescale[i*CNT_W +: CNT_W];
    // A half-period starts on the live value; later changes wait for the next start.
    assign limit    = (cnt == '0) ? prescale : shadow;
    assign at_limit = (cnt == limit);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        cnt    <= '0;
        shadow <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        rise_q <= 1'b0;
      end else if (sync_restart) begin
        cnt    <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        rise_q <= 1'b0;
      end else if (ch_enable[i]) begin
        if (cnt == '0) begin
          shadow <= prescale;
        end
        if (at_limit) begin
          cnt    <= '0;
          clk_q  <= ~clk_q;
          tick_q <= 1'b1;
          rise_q <= ~clk_q;
        end else begin
          cnt    <= cnt + CNT_W'(1);
          tick_q <= 1'b0;
          rise_q <= 1'b0;
        end
      end else begin
        tick_q <= 1'b0;
        rise_q <= 1'b0;
      end
    end

    assign clk_out[i]   = clk_q;
    assign tick[i]      = tick_q;
    assign rise_tick[i] = rise_q;
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench for clock_divider_bank: table-driven divider runs plus directed
// sequences, with expected toggle events queued at stimulus time and matched on each tick.
module tb_clock_divider_bank;
  localparam int NCH = 2;
  localparam int CW  = 16;

  logic              CLOCK_50 = 1'b0;
  logic              RESET_N;
  logic [NCH*CW-1:0] clk_prescale;
  logic [NCH-1:0]    ch_enable;
  logic              sync_restart;
  logic [NCH-1:0]    clk_out;
  logic [NCH-1:0]    tick;
  logic [NCH-1:0]    rise_tick;

  clock_divider_bank #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .CLOCK_50     (CLOCK_50),
    .RESET_N      (RESET_N),
    .clk_prescale (clk_prescale),
    .ch_enable    (ch_enable),
    .sync_restart (sync_restart),
    .clk_out      (clk_out),
    .tick         (tick),
    .rise_tick    (rise_tick)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int   cyc;
    logic lvl;
    logic rise;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int  lo[NCH] = '{0, 0};
  int  hi[NCH] = '{0, 0};
  logic [NCH-1:0] prev_clk = '0;

  typedef struct {
    logic [15:0] p0;
    logic [15:0] p1;
    logic [1:0]  en;
    int          half0;
    int          half1;
    int          len;
  } vec_t;

  vec_t vec[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input int t, input logic lvl);
    ev_t e;
    e.cyc  = t;
    e.lvl  = lvl;
    e.rise = lvl;
    if (c == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic check_ch(input int c);
    ev_t e;
    int  sz;
    sz = (c == 0) ? q0.size() : q1.size();
    if (tick[c]) begin
      chk($sformatf("ch%0d_tick_with_toggle", c), 32'(clk_out[c] ^ prev_clk[c]), 1);
      n_checks++;
      if (sz == 0) begin
        n_fail++;
        $display("FAIL ch%0d_unexpected_tick: tick=1 at cycle %0d, required no tick", c, cyc);
      end else begin
        if (c == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("ch%0d_toggle_cycle", c), cyc, e.cyc);
        chk($sformatf("ch%0d_toggle_level", c), 32'(clk_out[c]), 32'(e.lvl));
        chk($sformatf("ch%0d_rise_tick", c), 32'(rise_tick[c]), 32'(e.rise));
      end
    end else begin
      chk($sformatf("ch%0d_hold_level", c), 32'(clk_out[c]), 32'(prev_clk[c]));
      chk($sformatf("ch%0d_rise_without_tick", c), 32'(rise_tick[c]), 0);
    end
  endtask

  always @(negedge CLOCK_50) begin
    for (int c = 0; c < NCH; c++) begin
      if (cyc > lo[c] && cyc <= hi[c]) check_ch(c);
    end
    prev_clk = clk_out;
  end

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge CLOCK_50);
  endtask

  task automatic do_restart(output int r);
    sync_restart = 1'b1;
    @(negedge CLOCK_50);
    sync_restart = 1'b0;
    r = cyc;
  endtask

  task automatic open_win(input int r, input int len);
    for (int c = 0; c < NCH; c++) begin
      lo[c] = r;
      hi[c] = r + len;
    end
  endtask

  task automatic end_window(input string tag);
    wait_cyc(((hi[0] > hi[1]) ? hi[0] : hi[1]) + 1);
    chk({tag, "_ch0_pending"}, q0.size(), 0);
    chk({tag, "_ch1_pending"}, q1.size(), 0);
    q0.delete();
    q1.delete();
    lo = '{0, 0};
    hi = '{0, 0};
  endtask

  initial begin
    int r;
    int r2;
    int q;

    vec[0] = '{16'd520, 16'd0, 2'b11, 521, 1, 1570};
    vec[1] = '{16'd4,   16'd7, 2'b11, 5,   8, 40};
    vec[2] = '{16'd5,   16'd5, 2'b11, 6,   6, 30};
    vec[3] = '{16'd2,   16'd9, 2'b01, 3,   0, 20};
    vec[4] = '{16'd0,   16'd1, 2'b10, 0,   2, 12};

    RESET_N      = 1'b0;
    sync_restart = 1'b0;
    ch_enable    = '0;
    clk_prescale = '0;
    repeat (3) @(negedge CLOCK_50);
    chk("reset_clk_out", 32'(clk_out), 0);
    chk("reset_tick", 32'(tick), 0);
    chk("reset_rise_tick", 32'(rise_tick), 0);
    RESET_N = 1'b1;
    @(negedge CLOCK_50);

    for (int v = 0; v < 5; v++) begin
      clk_prescale = {vec[v].p1, vec[v].p0};
      ch_enable    = vec[v].en;
      do_restart(r);
      open_win(r, vec[v].len);
      for (int j = 0; j < vec[v].len; j++) begin
        if (vec[v].half0 > 0 && (j + 1) * vec[v].half0 <= vec[v].len)
          push_ev(0, r + (j + 1) * vec[v].half0, (j % 2) == 0);
        if (vec[v].half1 > 0 && (j + 1) * vec[v].half1 <= vec[v].len)
          push_ev(1, r + (j + 1) * vec[v].half1, (j % 2) == 0);
      end
      end_window($sformatf("vec%0d", v));
    end

    // Prescale raised mid-period: current half stays 5, following halves are 10.
    clk_prescale = {16'd0, 16'd4};
    ch_enable    = 2'b01;
    do_restart(r);
    open_win(r, 27);
    push_ev(0, r + 5, 1'b1);
    push_ev(0, r + 15, 1'b0);
    push_ev(0, r + 25, 1'b1);
    wait_cyc(r + 2);
    clk_prescale[15:0] = 16'd9;
    end_window("midchange");

    // Pause at counter 2 for 7 cycles; the toggle lands 2 cycles after re-enable.
    clk_prescale = {16'd0, 16'd3};
    ch_enable    = 2'b01;
    do_restart(r);
    open_win(r, 16);
    push_ev(0, r + 11, 1'b1);
    push_ev(0, r + 15, 1'b0);
    wait_cyc(r + 2);
    ch_enable = 2'b00;
    wait_cyc(r + 9);
    ch_enable = 2'b01;
    end_window("pause");

    // Staggered channels realigned by a restart that collides with ch0 terminal count.
    clk_prescale = {16'd5, 16'd5};
    ch_enable    = 2'b01;
    do_restart(r);
    open_win(r, 11);
    push_ev(0, r + 6, 1'b1);
    push_ev(1, r + 9, 1'b1);
    wait_cyc(r + 3);
    ch_enable = 2'b11;
    wait_cyc(r + 11);
    do_restart(r2);
    chk("restart_clk_out", 32'(clk_out), 0);
    chk("restart_tick", 32'(tick), 0);
    chk("restart_rise_tick", 32'(rise_tick), 0);
    chk("stagger_ch0_pending", q0.size(), 0);
    chk("stagger_ch1_pending", q1.size(), 0);
    open_win(r2, 13);
    push_ev(0, r2 + 6, 1'b1);
    push_ev(1, r2 + 6, 1'b1);
    push_ev(0, r2 + 12, 1'b0);
    push_ev(1, r2 + 12, 1'b0);
    end_window("realign");

    // Asynchronous reset while clk_out and tick are high; new prescale taken live on release.
    clk_prescale = {16'd0, 16'd4};
    ch_enable    = 2'b01;
    do_restart(r);
    open_win(r, 5);
    push_ev(0, r + 5, 1'b1);
    wait_cyc(r + 5);
    #2;
    chk("pre_reset_clk_out", 32'(clk_out[0]), 1);
    chk("pre_reset_tick", 32'(tick[0]), 1);
    RESET_N = 1'b0;
    #1;
    chk("async_reset_clk_out", 32'(clk_out), 0);
    chk("async_reset_tick", 32'(tick), 0);
    chk("async_reset_rise_tick", 32'(rise_tick), 0);
    chk("pre_reset_pending", q0.size(), 0);
    lo = '{0, 0};
    hi = '{0, 0};
    clk_prescale[15:0] = 16'd6;
    repeat (3) begin
      @(negedge CLOCK_50);
      chk("reset_hold_outputs", 32'({clk_out, tick, rise_tick}), 0);
    end
    RESET_N = 1'b1;
    q = cyc;
    open_win(q, 9);
    push_ev(0, q + 7, 1'b1);
    end_window("reset_release");

    // All-ones prescale: first toggle after 65536 cycles with no early wrap.
    clk_prescale = {16'd0, 16'hFFFF};
    ch_enable    = 2'b01;
    do_restart(r);
    open_win(r, 65538);
    push_ev(0, r + 65536, 1'b1);
    end_window("max_prescale");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1);
  end

endmodule

// File: doc/clock_divider_bank.md
CLOCK_DIVIDER_BANK -- requirements
Module: clock_divider_bank

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 16, width of each channel's prescale value and counter.
REQ-003 CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 clk_prescale  input  NUM_CH*CNT_W  per-channel prescale; channel i uses bits [i*CNT_W +: CNT_W].
REQ-006 ch_enable  input  NUM_CH  per-channel run enable.
REQ-007 sync_restart  input  1  synchronous restart of all channels.
REQ-008 clk_out  output  NUM_CH  per-channel divided square wave.
REQ-009 tick  output  NUM_CH  per-channel one-cycle strobe on every clk_out toggle.
REQ-010 rise_tick  output  NUM_CH  per-channel one-cycle strobe on every clk_out 0->1 toggle.

Function
REQ-011 Each channel SHALL contain a CNT_W-bit counter, a CNT_W-bit shadow prescale register, and the clk_out, tick and rise_tick registers.
REQ-012 Each channel's effective limit SHALL be the live prescale slice when its counter is 0, and its shadow register otherwise.
REQ-013 The shadow register SHALL load the live prescale slice on every enabled cycle where the counter is 0; mid-period prescale changes therefore take effect only at the next half-period start.
REQ-014 Enabled, counter != limit: counter SHALL increment by 1 and tick/rise_tick SHALL be 0.
REQ-015 Enabled, counter == limit: clk_out SHALL invert, counter SHALL clear to 0, tick SHALL be 1 for that next cycle, and rise_tick SHALL be 1 only if clk_out goes 0->1.
REQ-016 Half-period SHALL be (prescale+1) CLOCK_50 cycles and full period 2*(prescale+1); prescale 0 SHALL toggle clk_out every cycle.
REQ-017 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-018 Disabled channel: counter, shadow and clk_out SHALL hold; tick and rise_tick SHALL be 0.
REQ-019 Re-enable SHALL resume counting from the held counter value with no extra toggle.
REQ-020 sync_restart=1 SHALL, at the next edge, clear every counter and clk_out to 0 and force tick/rise_tick to 0, regardless of ch_enable.
REQ-021 sync_restart SHALL take priority over terminal count in the same cycle.
REQ-022 After sync_restart deasserts, all enabled channels with equal prescale SHALL toggle on the same cycle.
REQ-023 Counter SHALL never exceed the effective limit; arithmetic is unsigned CNT_W-bit with no wrap in normal operation.
REQ-024 Prescale all-ones SHALL give half-period 2^CNT_W cycles.
REQ-025 Channels SHALL be fully independent except for the shared sync_restart.

Reset
REQ-026 RESET_N low SHALL immediately clear all counters, shadow registers, clk_out, tick and rise_tick to 0, independent of CLOCK_50.
REQ-027 Reset asserted mid-period SHALL abandon that period; after deassertion each enabled channel SHALL count a full half-period from 0 using the live prescale.
REQ-028 Outputs SHALL remain 0 while RESET_N is low.

Verification
REQ-029 NUM_CH=2, CNT_W=16, prescale ch0=520, ch1=0, both enabled after reset -> ch0 toggles every 521 cycles (period 1042, ~47.98 kHz); ch1 toggles every cycle; one tick per toggle.
REQ-030 ch0 prescale 4; change to 9 at counter=2 -> current half-period stays 5 cycles, next half-periods are 10 cycles.
REQ-031 ch0 prescale 3; deassert ch_enable at counter=2 for 7 cycles -> clk_out frozen, tick=0; after re-enable, toggle occurs 2 cycles later.
REQ-032 Both channels prescale 5, ch1 started 3 cycles later; pulse sync_restart 1 cycle -> both clk_out=0 next cycle, then toggle together 6 cycles later.
REQ-033 Assert RESET_N low asynchronously mid-period with clk_out=1 -> clk_out, tick, rise_tick go 0 before the next edge; after release, first toggle after prescale+1 cycles with rise_tick=1.
REQ-034 Prescale 0xFFFF -> half-period 65536 cycles; counter never wraps and never exceeds 0xFFFF.
